// File: rtl/wb_regfile_if.sv
// Bus bundle between execute/decode/difftest and the writeback stage + register file.
// The master side drives results and read requests; the slave side (wb_regfile) answers.
interface wb_regfile_if #(
  parameter int REG_W  = 64,
  parameter int ADDR_W = 5
);
  logic              exe_valid_i;
  logic              exe_ready_o;
  logic [4:0]        inst_type_i;
  logic              rd_w_ena_i;
  logic [ADDR_W-1:0] rd_w_addr_i;
  logic [REG_W-1:0]  rd_data_i;
  logic              wb_stall_i;

  logic              r1_ena_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [REG_W-1:0]  r1_data_o;
  logic              r2_ena_i;
  logic [ADDR_W-1:0] r2_addr_i;
  logic [REG_W-1:0]  r2_data_o;

  logic              commit_valid_o;
  logic [4:0]        commit_type_o;
  logic              commit_wen_o;
  logic [ADDR_W-1:0] commit_waddr_o;
  logic [REG_W-1:0]  commit_wdata_o;
  logic [63:0]       instret_o;

  modport master (
    output exe_valid_i, inst_type_i, rd_w_ena_i, rd_w_addr_i, rd_data_i, wb_stall_i,
    output r1_ena_i, r1_addr_i, r2_ena_i, r2_addr_i,
    input  exe_ready_o, r1_data_o, r2_data_o,
    input  commit_valid_o, commit_type_o, commit_wen_o, commit_waddr_o, commit_wdata_o,
    input  instret_o
  );

  modport slave (
    input  exe_valid_i, inst_type_i, rd_w_ena_i, rd_w_addr_i, rd_data_i, wb_stall_i,
    input  r1_ena_i, r1_addr_i, r2_ena_i, r2_addr_i,
    output exe_ready_o, r1_data_o, r2_data_o,
    output commit_valid_o, commit_type_o, commit_wen_o, commit_waddr_o, commit_wdata_o,
    output instret_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage for the RV64 core: one-entry result register, 32x64 register file with
// bypassed combinational read ports, and a registered commit record plus instret counter.
module wb_regfile #(
  parameter int REG_W  = 64,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);

  logic              wbValid_q, wbValid_d;
  logic [4:0]        wbType_q, wbType_d;
  logic              wbWen_q, wbWen_d;
  logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
  logic [REG_W-1:0]  wbData_q, wbData_d;

  logic              commitValid_q, commitValid_d;
  logic [4:0]        commitType_q, commitType_d;
  logic              commitWen_q, commitWen_d;
  logic [ADDR_W-1:0] commitWaddr_q, commitWaddr_d;
  logic [REG_W-1:0]  commitWdata_q, commitWdata_d;
  logic [63:0]       instret_q, instret_d;

  logic [REG_W-1:0]  regs_q [NREG];

  logic              exeReady;
  logic              accept;
  logic              retire;
  logic              fileWrite;
  logic [REG_W-1:0]  r1Data;
  logic [REG_W-1:0]  r2Data;

  // A stalled entry blocks the slot; otherwise it drains on the same edge a new one enters.
  assign exeReady  = !wbValid_q || !bus.wb_stall_i;
  assign accept    = bus.exe_valid_i && exeReady;
  assign retire    = wbValid_q && !bus.wb_stall_i;
  assign fileWrite = retire && wbWen_q && (wbAddr_q != '0);

  always_comb begin
    wbValid_d     = wbValid_q;
    wbType_d      = wbType_q;
    wbWen_d       = wbWen_q;
    wbAddr_d      = wbAddr_q;
    wbData_d      = wbData_q;
    commitValid_d = retire;
    commitType_d  = commitType_q;
    commitWen_d   = commitWen_q;
    commitWaddr_d = commitWaddr_q;
    commitWdata_d = commitWdata_q;
    instret_d     = instret_q + {63'd0, retire};

    if (retire) begin
      wbValid_d     = 1'b0;
      commitType_d  = wbType_q;
      commitWen_d   = wbWen_q && (wbAddr_q != '0);
      commitWaddr_d = wbAddr_q;
      commitWdata_d = wbData_q;
    end
    if (accept) begin
      wbValid_d = 1'b1;
      wbType_d  = bus.inst_type_i;
      wbWen_d   = bus.rd_w_ena_i;
      wbAddr_d  = bus.rd_w_addr_i;
      wbData_d  = bus.rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid_q     <= 1'b0;
      wbType_q      <= '0;
      wbWen_q       <= 1'b0;
      wbAddr_q      <= '0;
      wbData_q      <= '0;
      commitValid_q <= 1'b0;
      commitType_q  <= '0;
      commitWen_q   <= 1'b0;
      commitWaddr_q <= '0;
      commitWdata_q <= '0;
      instret_q     <= '0;
    end else begin
      wbValid_q     <= wbValid_d;
      wbType_q      <= wbType_d;
      wbWen_q       <= wbWen_d;
      wbAddr_q      <= wbAddr_d;
      wbData_q      <= wbData_d;
      commitValid_q <= commitValid_d;
      commitType_q  <= commitType_d;
      commitWen_q   <= commitWen_d;
      commitWaddr_q <= commitWaddr_d;
      commitWdata_q <= commitWdata_d;
      instret_q     <= instret_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (fileWrite) begin
      regs_q[wbAddr_q] <= wbData_q;
    end
  end

  // The pending entry shadows the file so decode sees a result the cycle after execute.
  always_comb begin
    r1Data = '0;
    if (bus.r1_ena_i && (bus.r1_addr_i != '0)) begin
      if (wbValid_q && wbWen_q && (wbAddr_q == bus.r1_addr_i)) r1Data = wbData_q;
      else r1Data = regs_q[bus.r1_addr_i];
    end
  end

  always_comb begin
    r2Data = '0;
    if (bus.r2_ena_i && (bus.r2_addr_i != '0)) begin
      if (wbValid_q && wbWen_q && (wbAddr_q == bus.r2_addr_i)) r2Data = wbData_q;
      else r2Data = regs_q[bus.r2_addr_i];
    end
  end

  assign bus.exe_ready_o    = exeReady;
  assign bus.r1_data_o      = r1Data;
  assign bus.r2_data_o      = r2Data;
  assign bus.commit_valid_o = commitValid_q;
  assign bus.commit_type_o  = commitType_q;
  assign bus.commit_wen_o   = commitWen_q;
  assign bus.commit_waddr_o = commitWaddr_q;
  assign bus.commit_wdata_o = commitWdata_q;
  assign bus.instret_o      = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a per-cycle vector table covering write, bypass, x0,
// stall and back-to-back retirement, followed by a hand-written reset-mid-flight sequence.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_regfile_if #(.REG_W(64), .ADDR_W(5)) bus ();

  wb_regfile #(.REG_W(64), .NREG(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ty;
    logic        st;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic        rdy;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        cv;
    logic        cwen;
    logic [4:0]  cwa;
    logic [63:0] cwd;
    logic [4:0]  cty;
    logic [63:0] cnt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(
    input logic ev, input logic we, input logic [4:0] wa, input logic [63:0] wd,
    input logic [4:0] ty, input logic st, input logic e1, input logic [4:0] a1,
    input logic e2, input logic [4:0] a2, input logic rdy, input logic [63:0] d1,
    input logic [63:0] d2, input logic cv, input logic cwen, input logic [4:0] cwa,
    input logic [63:0] cwd, input logic [4:0] cty, input logic [63:0] cnt);
    vec_t v;
    v.ev = ev; v.we = we; v.wa = wa; v.wd = wd; v.ty = ty; v.st = st;
    v.e1 = e1; v.a1 = a1; v.e2 = e2; v.a2 = a2;
    v.rdy = rdy; v.d1 = d1; v.d2 = d2; v.cv = cv; v.cwen = cwen;
    v.cwa = cwa; v.cwd = cwd; v.cty = cty; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.exe_valid_i = v.ev;
    bus.rd_w_ena_i  = v.we;
    bus.rd_w_addr_i = v.wa;
    bus.rd_data_i   = v.wd;
    bus.inst_type_i = v.ty;
    bus.wb_stall_i  = v.st;
    bus.r1_ena_i    = v.e1;
    bus.r1_addr_i   = v.a1;
    bus.r2_ena_i    = v.e2;
    bus.r2_addr_i   = v.a2;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    checkOutput($sformatf("row%0d_ready", i), {63'd0, bus.exe_ready_o}, {63'd0, v.rdy});
    checkOutput($sformatf("row%0d_r1", i), bus.r1_data_o, v.d1);
    checkOutput($sformatf("row%0d_r2", i), bus.r2_data_o, v.d2);
    checkOutput($sformatf("row%0d_cvalid", i), {63'd0, bus.commit_valid_o}, {63'd0, v.cv});
    checkOutput($sformatf("row%0d_cwen", i), {63'd0, bus.commit_wen_o}, {63'd0, v.cwen});
    checkOutput($sformatf("row%0d_cwaddr", i), {59'd0, bus.commit_waddr_o}, {59'd0, v.cwa});
    checkOutput($sformatf("row%0d_cwdata", i), bus.commit_wdata_o, v.cwd);
    checkOutput($sformatf("row%0d_ctype", i), {59'd0, bus.commit_type_o}, {59'd0, v.cty});
    checkOutput($sformatf("row%0d_instret", i), bus.instret_o, v.cnt);
  endtask

  task automatic setReads(input logic [4:0] a1, input logic [4:0] a2);
    bus.r1_ena_i  = 1'b1;
    bus.r1_addr_i = a1;
    bus.r2_ena_i  = 1'b1;
    bus.r2_addr_i = a2;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Columns: ev we wa wd ty st e1 a1 e2 a2 | rdy d1 d2 cv cwen cwa cwd cty instret
    vecs[0]  = mk(1, 1, 3, 64'h1234, 1, 0, 1, 5, 1, 3,  1, 64'h0,    64'h0,    0, 0, 0, 64'h0,    0, 0);
    vecs[1]  = mk(0, 0, 0, 64'h0,    0, 0, 1, 3, 0, 3,  1, 64'h1234, 64'h0,    0, 0, 0, 64'h0,    0, 0);
    vecs[2]  = mk(1, 1, 0, 64'hFFFF, 2, 0, 1, 3, 1, 0,  1, 64'h1234, 64'h0,    1, 1, 3, 64'h1234, 1, 1);
    vecs[3]  = mk(0, 0, 0, 64'h0,    0, 0, 1, 0, 1, 3,  1, 64'h0,    64'h1234, 0, 1, 3, 64'h1234, 1, 1);
    vecs[4]  = mk(1, 1, 7, 64'hAA,   3, 0, 1, 0, 1, 3,  1, 64'h0,    64'h1234, 1, 0, 0, 64'hFFFF, 2, 2);
    vecs[5]  = mk(1, 1, 8, 64'hBB,   4, 1, 1, 7, 1, 8,  0, 64'hAA,   64'h0,    0, 0, 0, 64'hFFFF, 2, 2);
    vecs[6]  = mk(1, 1, 8, 64'hBB,   4, 1, 1, 7, 1, 8,  0, 64'hAA,   64'h0,    0, 0, 0, 64'hFFFF, 2, 2);
    vecs[7]  = mk(1, 1, 8, 64'hBB,   4, 1, 1, 7, 1, 8,  0, 64'hAA,   64'h0,    0, 0, 0, 64'hFFFF, 2, 2);
    vecs[8]  = mk(1, 1, 8, 64'hBB,   4, 0, 1, 7, 1, 8,  1, 64'hAA,   64'h0,    0, 0, 0, 64'hFFFF, 2, 2);
    vecs[9]  = mk(0, 0, 0, 64'h0,    0, 0, 1, 7, 1, 8,  1, 64'hAA,   64'hBB,   1, 1, 7, 64'hAA,   3, 3);
    vecs[10] = mk(1, 1, 1, 64'h1,    5, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h0,    1, 1, 8, 64'hBB,   4, 4);
    vecs[11] = mk(1, 1, 1, 64'h2,    5, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h1,    0, 1, 8, 64'hBB,   4, 4);
    vecs[12] = mk(1, 1, 1, 64'h3,    5, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h2,    1, 1, 1, 64'h1,    5, 5);
    vecs[13] = mk(1, 1, 1, 64'h4,    5, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h3,    1, 1, 1, 64'h2,    5, 6);
    vecs[14] = mk(0, 0, 0, 64'h0,    0, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h4,    1, 1, 1, 64'h3,    5, 7);
    vecs[15] = mk(0, 0, 0, 64'h0,    0, 0, 1, 8, 1, 1,  1, 64'hBB,   64'h4,    1, 1, 1, 64'h4,    5, 8);
    vecs[16] = mk(0, 0, 0, 64'h0,    0, 1, 0, 8, 1, 1,  1, 64'h0,    64'h4,    0, 1, 1, 64'h4,    5, 8);

    // Reset state
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 64'h0, 0, 0, 1, 5, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_r1_x5", bus.r1_data_o, 64'h0);
    checkOutput("reset_instret", bus.instret_o, 64'h0);
    checkOutput("reset_cvalid", {63'd0, bus.commit_valid_o}, 64'h0);
    checkOutput("reset_ready", {63'd0, bus.exe_ready_o}, 64'h1);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkRow(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset mid-flight: x9 pending when reset hits, and an accept offered during reset is ignored
    applyStimulus(mk(1, 1, 9, 64'h55, 6, 0, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    bus.rd_w_addr_i = 5'd10;
    bus.rd_data_i   = 64'h66;
    bus.wb_stall_i  = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("mid_bypass_x9", bus.r1_data_o, 64'h55);
    @(posedge clk);
    #1;
    bus.wb_stall_i = 1'b0;
    setReads(5'd9, 5'd1);
    #1;
    checkOutput("inrst_ready", {63'd0, bus.exe_ready_o}, 64'h1);
    checkOutput("inrst_cvalid", {63'd0, bus.commit_valid_o}, 64'h0);
    checkOutput("inrst_instret", bus.instret_o, 64'h0);
    checkOutput("inrst_x9", bus.r1_data_o, 64'h0);
    checkOutput("inrst_x1", bus.r2_data_o, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.exe_valid_i = 1'b0;
    setReads(5'd10, 5'd3);
    #1;
    checkOutput("post_x10", bus.r1_data_o, 64'h0);
    checkOutput("post_x3", bus.r2_data_o, 64'h0);
    checkOutput("post_cvalid", {63'd0, bus.commit_valid_o}, 64'h0);
    checkOutput("post_instret", bus.instret_o, 64'h0);
    @(posedge clk);
    #1;
    setReads(5'd9, 5'd7);
    #1;
    checkOutput("post2_x9", bus.r1_data_o, 64'h0);
    checkOutput("post2_x7", bus.r2_data_o, 64'h0);
    checkOutput("post2_cvalid", {63'd0, bus.commit_valid_o}, 64'h0);
    checkOutput("post2_instret", bus.instret_o, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
